// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one combinational 4-bit ALU
// between two requesters, with saturating per-opcode statistics counters.
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_in1,
    input  logic [3:0]       req0_in2,
    input  logic [1:0]       req0_op,
    input  logic [3:0]       req1_in1,
    input  logic [3:0]       req1_in2,
    input  logic [1:0]       req1_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_error,
    output logic [3:0]       alu_in1,
    output logic [3:0]       alu_in2,
    output logic [1:0]       alu_op,
    input  logic [3:0]       alu_out,
    input  logic             alu_err,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_add,
    output logic [CNT_W-1:0] cnt_sub,
    output logic [CNT_W-1:0] cnt_nand,
    output logic [CNT_W-1:0] cnt_xor,
    output logic [CNT_W-1:0] cnt_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_gnt;
    logic             r_owner;
    logic [3:0]       r_in1;
    logic [3:0]       r_in2;
    logic [1:0]       r_op;
    logic [3:0]       r_result;
    logic             r_error;
    logic [CNT_W-1:0] r_cnt_add;
    logic [CNT_W-1:0] r_cnt_sub;
    logic [CNT_W-1:0] r_cnt_nand;
    logic [CNT_W-1:0] r_cnt_xor;
    logic [CNT_W-1:0] r_cnt_err;
    logic             w_gnt;
    logic             w_gnt_en;
    logic             w_capture;
    logic             w_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        w_gnt = req_valid[1];
        if (req_valid == 2'b11) begin
            w_gnt = ~r_last_gnt;
        end
    end

    // Logic operations (op[1]=1) have no meaningful overflow.
    assign w_err = alu_err & ~r_op[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        w_gnt_en  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rst_n && (req_valid != 2'b00)) begin
                    w_gnt_en         = 1'b1;
                    req_ready[w_gnt] = 1'b1;
                    w_next           = S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture = 1'b1;
                w_next    = S_RESP;
            end
            S_RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
            r_owner    <= 1'b0;
            r_in1      <= '0;
            r_in2      <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_gnt_en) begin
                r_last_gnt <= w_gnt;
                r_owner    <= w_gnt;
                r_in1      <= w_gnt ? req1_in1 : req0_in1;
                r_in2      <= w_gnt ? req1_in2 : req0_in2;
                r_op       <= w_gnt ? req1_op  : req0_op;
            end
            if (w_capture) begin
                r_result <= alu_out;
                r_error  <= w_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_add  <= '0;
            r_cnt_sub  <= '0;
            r_cnt_nand <= '0;
            r_cnt_xor  <= '0;
            r_cnt_err  <= '0;
        end else if (w_capture) begin
            case (r_op)
                2'd0:    r_cnt_add  <= sat_inc(r_cnt_add);
                2'd1:    r_cnt_sub  <= sat_inc(r_cnt_sub);
                2'd2:    r_cnt_nand <= sat_inc(r_cnt_nand);
                default: r_cnt_xor  <= sat_inc(r_cnt_xor);
            endcase
            if (w_err) begin
                r_cnt_err <= sat_inc(r_cnt_err);
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign rsp_result = r_result;
    assign rsp_error  = r_error;
    assign alu_in1    = r_in1;
    assign alu_in2    = r_in2;
    assign alu_op     = r_op;
    assign cnt_add    = r_cnt_add;
    assign cnt_sub    = r_cnt_sub;
    assign cnt_nand   = r_cnt_nand;
    assign cnt_xor    = r_cnt_xor;
    assign cnt_err    = r_cnt_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized bench for alu_arbiter with a
// transaction-level reference model and a behavioural 4-bit ALU.
module tb_alu_arbiter;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req0_in1, req0_in2, req1_in1, req1_in2;
    logic [1:0]       req0_op, req1_op;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [3:0]       rsp_result;
    logic             rsp_error;
    logic [3:0]       alu_in1, alu_in2, alu_out;
    logic [1:0]       alu_op;
    logic             alu_err;
    logic             busy;
    logic [CNT_W-1:0] cnt_add, cnt_sub, cnt_nand, cnt_xor, cnt_err;

    logic             force_err;
    logic [4:0]       w_alu;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit         m_busy;
    int         m_phase;
    int         m_owner;
    int         m_last;
    logic [3:0] m_a, m_b, m_res;
    logic [1:0] m_op;
    bit         m_err;
    int         m_cnt[4];
    int         m_cnt_err;

    logic [1:0] dut_gnt;
    logic [1:0] gnt_log[$];
    bit         cont;
    bit         rand_mode;
    int         e_before;

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_err(alu_err),
        .busy(busy),
        .cnt_add(cnt_add), .cnt_sub(cnt_sub), .cnt_nand(cnt_nand),
        .cnt_xor(cnt_xor), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    // {overflow, result} of the shared ALU, overflow as signed 4-bit arithmetic
    function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
        int sa, sb, r;
        logic [3:0] y;
        sa = (a > 7) ? int'(a) - 16 : int'(a);
        sb = (b > 7) ? int'(b) - 16 : int'(b);
        r  = 0;
        case (op)
            2'd0:    begin r = sa + sb; y = a + b; end
            2'd1:    begin r = sa - sb; y = a - b; end
            2'd2:    y = ~(a & b);
            default: y = a ^ b;
        endcase
        return {(op < 2) && (r > 7 || r < -8), y};
    endfunction

    assign w_alu   = alu_ref(alu_in1, alu_in2, alu_op);
    assign alu_out = w_alu[3:0];
    assign alu_err = w_alu[4] | force_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_phase = 0; m_owner = 0; m_last = 1;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_cnt_err = 0;
    endtask

    // Called at the falling edge: compare, then advance to the next rising edge.
    task automatic model_cycle();
        int g;
        logic [4:0] r;
        if (!rst_n) model_reset();
        g = -1;
        if (rst_n && !m_busy) begin
            if (req_valid == 2'b11) g = 1 - m_last;
            else if (req_valid[0])  g = 0;
            else if (req_valid[1])  g = 1;
        end
        check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        check("rsp_valid", rsp_valid, (m_busy && m_phase == 2) ? (1 << m_owner) : 0);
        check("busy", busy, m_busy);
        check("rsp_result", rsp_result, m_res);
        check("rsp_error", rsp_error, m_err);
        check("alu_in1", alu_in1, m_a);
        check("alu_in2", alu_in2, m_b);
        check("alu_op", alu_op, m_op);
        check("cnt_add", cnt_add, m_cnt[0]);
        check("cnt_sub", cnt_sub, m_cnt[1]);
        check("cnt_nand", cnt_nand, m_cnt[2]);
        check("cnt_xor", cnt_xor, m_cnt[3]);
        check("cnt_err", cnt_err, m_cnt_err);
        dut_gnt = req_ready;
        if (req_ready != 2'b00) gnt_log.push_back(req_ready);
        if (!rst_n) return;
        if (g >= 0) begin
            m_busy = 1'b1; m_phase = 1; m_owner = g; m_last = g;
            m_a  = (g == 1) ? req1_in1 : req0_in1;
            m_b  = (g == 1) ? req1_in2 : req0_in2;
            m_op = (g == 1) ? req1_op  : req0_op;
        end else if (m_busy && m_phase == 1) begin
            r     = alu_ref(m_a, m_b, m_op);
            m_res = r[3:0];
            m_err = (m_op < 2) && (r[4] || force_err);
            if (m_cnt[m_op] < CMAX) m_cnt[m_op]++;
            if (m_err && m_cnt_err < CMAX) m_cnt_err++;
            m_phase = 2;
        end else if (m_busy && rsp_ready[m_owner]) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op);
        if (i == 0) begin req0_in1 = a; req0_in2 = b; req0_op = op; end
        else        begin req1_in1 = a; req1_in2 = b; req1_op = op; end
        req_valid[i] = 1'b1;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
                set_req(i, 4'($urandom), 4'($urandom), 2'($urandom));
            else if (req_valid[i] && $urandom_range(0, 19) == 0)
                req_valid[i] = 1'b0;
        end
        rsp_ready = 2'($urandom);
        force_err = ($urandom_range(0, 7) == 0);
    endtask

    task automatic cycle();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (dut_gnt[i] && !cont) req_valid[i] = 1'b0;
        if (rand_mode) randomize_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        gnt_log.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; force_err = 1'b0;
        req0_in1 = '0; req0_in2 = '0; req0_op = '0;
        req1_in1 = '0; req1_in2 = '0; req1_op = '0;
        cont = 1'b0; rand_mode = 1'b0; dut_gnt = '0;
        model_reset();
        do_reset();

        // single ADD 7+1 from requester 0
        set_req(0, 4'h7, 4'h1, 2'd0);
        rsp_ready = 2'b01;
        repeat (4) cycle();
        check("t1_gnt_count", gnt_log.size(), 1);
        if (gnt_log.size() > 0) check("t1_gnt", gnt_log[0], 2'b01);
        check("t1_result", rsp_result, 4'h8);
        check("t1_error", rsp_error, 1'b1);
        check("t1_cnt_add", cnt_add, 1);
        check("t1_cnt_err", cnt_err, 1);

        // tie after reset: grants alternate starting with requester 0
        do_reset();
        set_req(0, 4'h3, 4'h5, 2'd1);
        set_req(1, 4'hA, 4'h6, 2'd3);
        cont = 1'b1;
        rsp_ready = 2'b11;
        repeat (12) cycle();
        cont = 1'b0;
        req_valid = '0;
        check("tie_gnt_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check("tie_gnt", gnt_log[i], (i % 2 == 1) ? 2'b10 : 2'b01);
        check("tie_last_result", rsp_result, 4'hC);
        check("tie_last_error", rsp_error, 1'b0);

        // backpressure, with the non-owner's rsp_ready asserted meanwhile
        set_req(1, 4'h4, 4'h5, 2'd0);
        rsp_ready = 2'b00;
        cycle();
        cycle();
        rsp_ready = 2'b01;
        repeat (5) cycle();
        rsp_ready = 2'b10;
        cycle();
        cycle();
        check("bp_result", rsp_result, 4'h9);
        check("bp_error", rsp_error, 1'b1);

        // NAND with forced ALU error: error must be masked
        e_before = m_cnt_err;
        force_err = 1'b1;
        set_req(0, 4'hF, 4'hF, 2'd2);
        rsp_ready = 2'b01;
        repeat (4) cycle();
        force_err = 1'b0;
        check("nand_result", rsp_result, 4'h0);
        check("nand_error", rsp_error, 1'b0);
        check("nand_cnt_err", cnt_err, e_before);

        // reset while in EXEC
        set_req(0, 4'h3, 4'h5, 2'd1);
        rsp_ready = 2'b01;
        cycle();
        rst_n = 1'b0;
        req_valid = '0;
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        gnt_log.delete();
        set_req(0, 4'h1, 4'h2, 2'd0);
        set_req(1, 4'h2, 4'h3, 2'd1);
        rsp_ready = 2'b11;
        cycle();
        check("rst_tie_count", gnt_log.size(), 1);
        if (gnt_log.size() > 0) check("rst_tie_gnt", gnt_log[0], 2'b01);
        repeat (6) cycle();

        // saturation: five XOR operations on a 2-bit counter
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_req(1, 4'($urandom), 4'($urandom), 2'd3);
            rsp_ready = 2'b10;
            repeat (3) cycle();
        end
        check("sat_cnt_xor", cnt_xor, 3);
        cycle();
        check("sat_cnt_xor_hold", cnt_xor, 3);

        // randomized traffic
        do_reset();
        rand_mode = 1'b1;
        repeat (2000) cycle();
        rand_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
